load_mem_ctrl: RTL and testbench

Load-side memory access sequencer that sits directly upstream of the load data converter. It accepts a load request from the control unit and checks alignment against the IR load type. It then runs a req/ack read on the data-memory bus and captures the raw 32-bit word. The captured word, IR and byte offset are presented as stable registered outputs for the converter to consume.

---
 rtl/load_mem_ctrl.sv | 151 +++++++++++++++
 tb/tb_load_mem_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_mem_ctrl.sv
// Load-side memory access sequencer: checks alignment against the IR load type,
// runs a req/ack word read, and presents word, IR and byte offset to the load converter.
module load_mem_ctrl #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CW      = 8
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] ir_i,
  output logic        mem_rd_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] ld_ir_o,
  output logic [1:0]  ld_offset_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [1:0]  err_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    REQ   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_FUNCT3  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e        state_q;
  logic [29:0]   addr_hi_q;
  logic          mem_rd_q;
  logic [31:0]   mem_addr_q;
  logic [31:0]   ld_data_q;
  logic [31:0]   ld_ir_q;
  logic [1:0]    ld_offset_q;
  logic          busy_q;
  logic          done_q;
  logic [1:0]    err_q;
  logic [CW-1:0] cnt_q;

  logic [2:0] funct3;
  logic       illegal_f3;
  logic       misaligned;

  assign funct3 = ld_ir_q[14:12];

  // Checks run on the latched IR/offset so CHECK sees exactly what was accepted.
  always_comb begin
    illegal_f3 = 1'b1;
    misaligned = 1'b0;
    case (funct3)
      3'b000, 3'b100: illegal_f3 = 1'b0;
      3'b001, 3'b101: begin
        illegal_f3 = 1'b0;
        misaligned = ld_offset_q[0];
      end
      3'b010: begin
        illegal_f3 = 1'b0;
        misaligned = |ld_offset_q;
      end
      default: illegal_f3 = 1'b1;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      addr_hi_q   <= '0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      ld_data_q   <= '0;
      ld_ir_q     <= '0;
      ld_offset_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= ERR_OK;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            addr_hi_q   <= addr_i[31:2];
            ld_ir_q     <= ir_i;
            ld_offset_q <= addr_i[1:0];
            err_q       <= ERR_OK;
            busy_q      <= 1'b1;
            state_q     <= CHECK;
          end
        end
        CHECK: begin
          if (illegal_f3) begin
            err_q   <= ERR_FUNCT3;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (misaligned) begin
            err_q   <= ERR_ALIGN;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            mem_rd_q   <= 1'b1;
            mem_addr_q <= {addr_hi_q, 2'b00};
            cnt_q      <= '0;
            state_q    <= REQ;
          end
        end
        REQ: begin
          // An ack on the final allowed cycle still counts as success.
          if (mem_ack_i) begin
            ld_data_q <= mem_rdata_i;
            mem_rd_q  <= 1'b0;
            err_q     <= ERR_OK;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end else if (cnt_q == CNT_LAST) begin
            mem_rd_q <= 1'b0;
            err_q    <= ERR_TIMEOUT;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_rd_o    = mem_rd_q;
  assign mem_addr_o  = mem_addr_q;
  assign ld_data_o   = ld_data_q;
  assign ld_ir_o     = ld_ir_q;
  assign ld_offset_o = ld_offset_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_load_mem_ctrl.sv
// Directed bench for load_mem_ctrl (TIMEOUT=4): alignment, funct3, timeout,
// ack-at-boundary and mid-transaction reset, against hand-computed expectations.
module tb_load_mem_ctrl;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [31:0] addr_i;
  logic [31:0] ir_i;
  logic        mem_rd_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] ld_data_o;
  logic [31:0] ld_ir_o;
  logic [1:0]  ld_offset_o;
  logic        busy_o;
  logic        done_o;
  logic [1:0]  err_o;

  int n_vec  = 0;
  int n_miss = 0;

  load_mem_ctrl #(.TIMEOUT(4), .CW(8)) dut (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .start_i     (start_i),
    .addr_i      (addr_i),
    .ir_i        (ir_i),
    .mem_rd_o    (mem_rd_o),
    .mem_addr_o  (mem_addr_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .ld_data_o   (ld_data_o),
    .ld_ir_o     (ld_ir_o),
    .ld_offset_o (ld_offset_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  function automatic logic [31:0] mk_ir(input logic [2:0] f3);
    return {17'h0, f3, 12'h003};
  endfunction

  // Issues one load; ack_at = index of the mem_rd cycle that gets acked, -1 for none.
  // Returns with the bench sitting in the DONE cycle (or after the cycle budget).
  task automatic do_load(input logic [31:0] a, input logic [31:0] ir, input int ack_at,
                         input logic [31:0] rd, input logic [31:0] exp_maddr,
                         output int rd_cycles, output int done_cyc);
    logic addr_ok;
    addr_ok   = 1'b1;
    rd_cycles = 0;
    done_cyc  = -1;
    start_i   = 1'b1;
    addr_i    = a;
    ir_i      = ir;
    step();
    start_i = 1'b0;
    for (int cyc = 1; cyc < 30; cyc++) begin
      if (done_o) begin
        done_cyc = cyc;
        break;
      end
      mem_ack_i = 1'b0;
      if (mem_rd_o) begin
        if (mem_addr_o !== exp_maddr) addr_ok = 1'b0;
        if (rd_cycles == ack_at) begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = rd;
        end
        rd_cycles++;
      end
      step();
      mem_ack_i = 1'b0;
    end
    if (rd_cycles > 0) chk("mem_addr_held", {31'h0, addr_ok}, 32'h1);
  endtask

  int rc, dc;

  initial begin
    reset_i     = 1'b1;
    start_i     = 1'b0;
    addr_i      = '0;
    ir_i        = '0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    step();
    step();
    reset_i = 1'b0;
    step();
    chk("rst_mem_rd", {31'h0, mem_rd_o}, 0);
    chk("rst_busy",   {31'h0, busy_o}, 0);
    chk("rst_done",   {31'h0, done_o}, 0);
    chk("rst_err",    {30'h0, err_o}, 0);
    chk("rst_ld_data", ld_data_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);

    // LW aligned, ack on 4th mem_rd cycle (also the timeout boundary)
    do_load(32'h100, mk_ir(3'b010), 3, 32'hDEADBEEF, 32'h100, rc, dc);
    chk("lw_rd_cycles", rc, 4);
    chk("lw_done_cyc",  dc, 6);
    chk("lw_err",       {30'h0, err_o}, 0);
    chk("lw_data",      ld_data_o, 32'hDEADBEEF);
    chk("lw_offset",    {30'h0, ld_offset_o}, 0);
    chk("lw_ir",        ld_ir_o, mk_ir(3'b010));
    chk("lw_busy_done", {31'h0, busy_o}, 1);
    chk("lw_mem_rd_off", {31'h0, mem_rd_o}, 0);
    step();
    chk("lw_done_clr",  {31'h0, done_o}, 0);
    chk("lw_busy_clr",  {31'h0, busy_o}, 0);

    // LB with offset 3, immediate ack; start is back-to-back with the idle cycle
    do_load(32'h203, mk_ir(3'b000), 0, 32'h80FF1234, 32'h200, rc, dc);
    chk("lb_rd_cycles", rc, 1);
    chk("lb_done_cyc",  dc, 3);
    chk("lb_err",       {30'h0, err_o}, 0);
    chk("lb_data",      ld_data_o, 32'h80FF1234);
    chk("lb_offset",    {30'h0, ld_offset_o}, 3);
    chk("lb_mem_addr",  mem_addr_o, 32'h200);
    step();
    chk("lb_err_hold",  {30'h0, err_o}, 0);

    // LH misaligned
    do_load(32'h11, mk_ir(3'b001), 0, 32'h11111111, 32'h0, rc, dc);
    chk("lh_mis_rd",    rc, 0);
    chk("lh_mis_done",  dc, 2);
    chk("lh_mis_err",   {30'h0, err_o}, 1);
    chk("lh_mis_data",  ld_data_o, 32'h80FF1234);
    chk("lh_mis_off",   {30'h0, ld_offset_o}, 1);
    step();
    chk("lh_mis_err_hold", {30'h0, err_o}, 1);

    // LW misaligned by half-word
    do_load(32'h12, mk_ir(3'b010), 0, 32'h22222222, 32'h0, rc, dc);
    chk("lw_mis_rd",    rc, 0);
    chk("lw_mis_err",   {30'h0, err_o}, 1);
    step();

    // LHU at half-word offset is legal
    do_load(32'h2002, mk_ir(3'b101), 1, 32'h12345678, 32'h2000, rc, dc);
    chk("lhu_rd",       rc, 2);
    chk("lhu_done",     dc, 4);
    chk("lhu_err",      {30'h0, err_o}, 0);
    chk("lhu_data",     ld_data_o, 32'h12345678);
    chk("lhu_off",      {30'h0, ld_offset_o}, 2);
    step();

    // LBU at odd offset
    do_load(32'h7, mk_ir(3'b100), 0, 32'hCAFEF00D, 32'h4, rc, dc);
    chk("lbu_err",      {30'h0, err_o}, 0);
    chk("lbu_data",     ld_data_o, 32'hCAFEF00D);
    step();

    // Illegal funct3 values
    for (int f = 3; f < 8; f++) begin
      if (f == 4 || f == 5) continue;
      do_load(32'h40, mk_ir(3'(f)), 0, 32'h33333333, 32'h0, rc, dc);
      chk("ill_rd",     rc, 0);
      chk("ill_done",   dc, 2);
      chk("ill_err",    {30'h0, err_o}, 2);
      chk("ill_data",   ld_data_o, 32'hCAFEF00D);
      step();
    end

    // Timeout: no ack
    do_load(32'h300, mk_ir(3'b010), -1, 32'h0, 32'h300, rc, dc);
    chk("to_rd_cycles", rc, 4);
    chk("to_done_cyc",  dc, 6);
    chk("to_err",       {30'h0, err_o}, 3);
    chk("to_data",      ld_data_o, 32'hCAFEF00D);
    step();

    // Ack on 4th cycle wins over timeout
    do_load(32'h304, mk_ir(3'b010), 3, 32'hA5A5A5A5, 32'h304, rc, dc);
    chk("tob_rd_cycles", rc, 4);
    chk("tob_err",      {30'h0, err_o}, 0);
    chk("tob_data",     ld_data_o, 32'hA5A5A5A5);
    step();

    // Reset while mem_rd is high
    start_i = 1'b1;
    addr_i  = 32'h500;
    ir_i    = mk_ir(3'b010);
    step();
    start_i = 1'b0;
    step();
    chk("mid_mem_rd_up", {31'h0, mem_rd_o}, 1);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    chk("mid_rst_mem_rd", {31'h0, mem_rd_o}, 0);
    chk("mid_rst_busy",   {31'h0, busy_o}, 0);
    chk("mid_rst_data",   ld_data_o, 0);
    chk("mid_rst_ir",     ld_ir_o, 0);
    chk("mid_rst_addr",   mem_addr_o, 0);
    chk("mid_rst_off",    {30'h0, ld_offset_o}, 0);
    chk("mid_rst_err",    {30'h0, err_o}, 0);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hBADBAD00;
    step();
    mem_ack_i = 1'b0;
    step();
    chk("stray_ack_data", ld_data_o, 0);
    chk("stray_ack_busy", {31'h0, busy_o}, 0);
    chk("stray_ack_done", {31'h0, done_o}, 0);

    do_load(32'h600, mk_ir(3'b010), 0, 32'h0BADF00D, 32'h600, rc, dc);
    chk("post_rst_done", dc, 3);
    chk("post_rst_err",  {30'h0, err_o}, 0);
    chk("post_rst_data", ld_data_o, 32'h0BADF00D);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
